// File: rtl/aes_mode_engine_if.sv
// Stream and control bundle between the DMA/stream fabric and the AES mode engine.
// The fabric side uses the master modport and the engine uses the slave modport.
interface aes_mode_engine_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [1:0]       cfg_mode;
    logic [127:0]     cfg_key;
    logic [127:0]     cfg_iv;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic             out_last;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] blk_cnt;

    modport master (
        output start, cfg_mode, cfg_key, cfg_iv, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, err, blk_cnt
    );

    modport slave (
        input  start, cfg_mode, cfg_key, cfg_iv, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, err, blk_cnt
    );
endinterface

// File: rtl/aes_mode_engine.sv
// AES-128 mode engine: ECB/CBC/CTR streaming wrapper around a single-shot
// aes_cipher_top core, with one block in flight, message framing, a result
// counter and a watchdog on the core's done pulse.

// Iterative AES-128 encryption core: ld starts a block, done pulses one cycle
// when text_out holds the ciphertext. rst is active-low.
module aes_cipher_top (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    output logic         done,
    input  logic [127:0] key,
    input  logic [127:0] text_in,
    output logic [127:0] text_out
);
    logic [127:0] st, rk, nk, sr, mc;
    logic [7:0]   rcon;
    logic [3:0]   round;
    logic         active;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, v;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        v    = gmul(gmul(x240, x12), x2);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            r[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return r;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Round datapath: next round key and the round function on the current state
    always_comb begin
        nk = next_key(rk, rcon);
        sr = shift_rows(sub_bytes(st));
        mc = mix_columns(sr);
    end

    // One round per cycle; the tenth round skips MixColumns and raises done
    always_ff @(posedge clk) begin
        if (!rst) begin
            st       <= '0;
            rk       <= '0;
            rcon     <= 8'h01;
            round    <= 4'd0;
            active   <= 1'b0;
            done     <= 1'b0;
            text_out <= '0;
        end else begin
            done <= 1'b0;
            if (ld) begin
                st     <= text_in ^ key;
                rk     <= key;
                rcon   <= 8'h01;
                round  <= 4'd1;
                active <= 1'b1;
            end else if (active) begin
                rk <= nk;
                if (round == 4'd10) begin
                    text_out <= sr ^ nk;
                    done     <= 1'b1;
                    active   <= 1'b0;
                end else begin
                    st    <= mc ^ nk;
                    rcon  <= gmul(rcon, 8'h02);
                    round <= round + 4'd1;
                end
            end
        end
    end
endmodule

module aes_mode_engine #(
    parameter int CTR_W   = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input logic              clk,
    input logic              rst,
    aes_mode_engine_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARM, LOAD, WAIT, HOLD} state_t;

    localparam logic [1:0]   MODE_CBC = 2'd1;
    localparam logic [1:0]   MODE_CTR = 2'd2;
    localparam logic [1:0]   MODE_RSV = 2'd3;
    localparam int           WCW      = $clog2(TIMEOUT);
    localparam logic [127:0] CTR_MASK = (128'd1 << CTR_W) - 128'd1;

    state_t           state;
    logic [127:0]     key_q, chain_q, ctr_q, p_q, out_data_q;
    logic [127:0]     core_text_in, core_text_out;
    logic [127:0]     text_sel, result, ctr_next;
    logic [1:0]       mode_q;
    logic             last_q, core_ld, core_done, core_rst_n;
    logic             in_ready_q, out_valid_q, out_last_q, busy_q, err_q;
    logic [CNT_W-1:0] blk_cnt_q;
    logic [WCW-1:0]   wait_cnt;

    assign core_rst_n = ~rst;

    aes_cipher_top u_core (
        .clk      (clk),
        .rst      (core_rst_n),
        .ld       (core_ld),
        .done     (core_done),
        .key      (key_q),
        .text_in  (core_text_in),
        .text_out (core_text_out)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.blk_cnt   = blk_cnt_q;

    // Mode-dependent core input, core result after CTR whitening, and the next counter
    always_comb begin
        text_sel = bus.in_data;
        case (mode_q)
            MODE_CBC: text_sel = bus.in_data ^ chain_q;
            MODE_CTR: text_sel = ctr_q;
            default:  text_sel = bus.in_data;
        endcase
        result   = (mode_q == MODE_CTR) ? (core_text_out ^ p_q) : core_text_out;
        ctr_next = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
    end

    // Message FSM: accept one block, run the core, hold the result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            key_q        <= '0;
            chain_q      <= '0;
            ctr_q        <= '0;
            p_q          <= '0;
            mode_q       <= '0;
            last_q       <= 1'b0;
            core_ld      <= 1'b0;
            core_text_in <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            blk_cnt_q    <= '0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.cfg_mode == MODE_RSV) begin
                            err_q <= 1'b1;
                        end else begin
                            key_q      <= bus.cfg_key;
                            mode_q     <= bus.cfg_mode;
                            chain_q    <= bus.cfg_iv;
                            ctr_q      <= bus.cfg_iv;
                            err_q      <= 1'b0;
                            blk_cnt_q  <= '0;
                            busy_q     <= 1'b1;
                            in_ready_q <= 1'b1;
                            state      <= ARM;
                        end
                    end
                end
                ARM: begin
                    if (bus.in_valid && in_ready_q) begin
                        in_ready_q   <= 1'b0;
                        p_q          <= bus.in_data;
                        last_q       <= bus.in_last;
                        core_text_in <= text_sel;
                        core_ld      <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    core_ld  <= 1'b0;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        out_data_q  <= result;
                        out_last_q  <= last_q;
                        out_valid_q <= 1'b1;
                        if (mode_q == MODE_CBC) chain_q <= result;
                        if (mode_q == MODE_CTR) ctr_q <= ctr_next;
                        state <= HOLD;
                    end else if (wait_cnt == WCW'(TIMEOUT - 2)) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        blk_cnt_q   <= blk_cnt_q + CNT_W'(1);
                        if (out_last_q) begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            in_ready_q <= 1'b1;
                            state      <= ARM;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (bus.start && state != IDLE) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_aes_mode_engine.sv
// Scoreboard bench for aes_mode_engine using FIPS-197 / SP800-38A vectors,
// counter-wrap probing, backpressure, framing and error scenarios.
module tb_aes_mode_engine;
    localparam int CTR_W   = 32;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 64;

    localparam logic [127:0] KEY_A  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_A   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV_CBC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CBC_C1 = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] CBC_C2 = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] IV_CTR = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] CTR_C1 = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] CTR_C2 = 128'h9806f66b7970fdff8617187bb9fffdff;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    aes_mode_engine_if #(.CNT_W(CNT_W)) bus ();

    aes_mode_engine #(.CTR_W(CTR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [127:0] data;
        logic         last;
        logic         chk;
    } exp_t;

    int           checks   = 0;
    int           failures = 0;
    int           hs_cnt   = 0;
    exp_t         sb[$];
    exp_t         sb_head;
    logic [127:0] ld_log[$];

    task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Record every core load and score every result handshake against the queue
    always @(negedge clk) begin
        if (!rst) begin
            if (dut.core_ld) ld_log.push_back(dut.core_text_in);
            if (bus.out_valid && bus.out_ready) begin
                hs_cnt++;
                check_output("sb_has_entry", 128'(sb.size() != 0), 128'd1);
                if (sb.size() != 0) begin
                    sb_head = sb.pop_front();
                    if (sb_head.chk) check_output("out_data", bus.out_data, sb_head.data);
                    check_output("out_last", 128'(bus.out_last), 128'(sb_head.last));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_msg(input logic [1:0] mode, input logic [127:0] key, input logic [127:0] iv);
        bus.cfg_mode = mode;
        bus.cfg_key  = key;
        bus.cfg_iv   = iv;
        bus.start    = 1'b1;
        ld_log.delete();
        tick();
        bus.start = 1'b0;
    endtask

    // Offer one block; returns in the cycle the core load is asserted
    task automatic apply_stimulus(input logic [127:0] data, input logic last, input logic [127:0] exp,
                                  input logic chk, input logic expect_out);
        int   n = 0;
        exp_t e;
        e = '{data: exp, last: last, chk: chk};
        if (expect_out) sb.push_back(e);
        bus.in_data  = data;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 300) begin
            tick();
            n++;
        end
        check_output("in_ready_seen", 128'(bus.in_ready), 128'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_msg_done();
        int n = 0;
        while ((bus.busy || bus.out_valid) && n < 500) begin
            tick();
            n++;
        end
        check_output("msg_done", {126'd0, bus.busy, bus.out_valid}, 128'd0);
    endtask

    task automatic check_reset_outputs(input string p);
        check_output({p, "_in_ready"},  128'(bus.in_ready),  128'd0);
        check_output({p, "_out_valid"}, 128'(bus.out_valid), 128'd0);
        check_output({p, "_out_data"},  bus.out_data,        128'd0);
        check_output({p, "_out_last"},  128'(bus.out_last),  128'd0);
        check_output({p, "_busy"},      128'(bus.busy),      128'd0);
        check_output({p, "_err"},       128'(bus.err),       128'd0);
        check_output({p, "_blk_cnt"},   128'(bus.blk_cnt),   128'd0);
    endtask

    // Hard stop in case something wedges outside the bounded waits
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Directed scenarios; results are scored by the monitor
    initial begin
        logic [127:0] iv;
        int           n;
        int           hs_base;

        bus.start     = 1'b0;
        bus.cfg_mode  = 2'd0;
        bus.cfg_key   = '0;
        bus.cfg_iv    = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        rst = 1'b1;
        repeat (3) tick();
        check_reset_outputs("por");
        rst = 1'b0;
        tick();

        $display("[TB] ECB single block");
        start_msg(2'd0, KEY_A, '0);
        check_output("ecb_busy", 128'(bus.busy), 128'd1);
        apply_stimulus(PT_A, 1'b1, CT_A, 1'b1, 1'b1);
        wait_msg_done();
        check_output("ecb_blk_cnt", 128'(bus.blk_cnt), 128'd1);
        check_output("ecb_err", 128'(bus.err), 128'd0);

        $display("[TB] CBC two blocks");
        start_msg(2'd1, KEY_B, IV_CBC);
        apply_stimulus(P1, 1'b0, CBC_C1, 1'b1, 1'b1);
        apply_stimulus(P2, 1'b1, CBC_C2, 1'b1, 1'b1);
        wait_msg_done();
        check_output("cbc_blk_cnt", 128'(bus.blk_cnt), 128'd2);
        check_output("cbc_ld_count", 128'(ld_log.size()), 128'd2);
        if (ld_log.size() >= 2) begin
            check_output("cbc_core_in0", ld_log[0], P1 ^ IV_CBC);
            check_output("cbc_core_in1", ld_log[1], P2 ^ CBC_C1);
        end

        $display("[TB] CTR two blocks");
        iv = IV_CTR;
        start_msg(2'd2, KEY_B, iv);
        apply_stimulus(P1, 1'b0, CTR_C1, 1'b1, 1'b1);
        apply_stimulus(P2, 1'b1, CTR_C2, 1'b1, 1'b1);
        wait_msg_done();
        check_output("ctr_blk_cnt", 128'(bus.blk_cnt), 128'd2);
        check_output("ctr_ld_count", 128'(ld_log.size()), 128'd2);
        if (ld_log.size() >= 2) begin
            check_output("ctr_core_in0", ld_log[0], iv);
            check_output("ctr_core_in1", ld_log[1], {iv[127:32], iv[31:0] + 32'd1});
        end

        $display("[TB] CTR low-word wrap");
        iv = {96'd0, 32'hffffffff};
        start_msg(2'd2, KEY_B, iv);
        apply_stimulus(P1, 1'b0, '0, 1'b0, 1'b1);
        apply_stimulus(P2, 1'b1, '0, 1'b0, 1'b1);
        wait_msg_done();
        check_output("wrap_ld_count", 128'(ld_log.size()), 128'd2);
        if (ld_log.size() >= 2) begin
            check_output("wrap_core_in0", ld_log[0], iv);
            check_output("wrap_core_in1", ld_log[1], {iv[127:32], 32'd0});
        end

        $display("[TB] Backpressure");
        start_msg(2'd0, KEY_A, '0);
        bus.out_ready = 1'b0;
        apply_stimulus(PT_A, 1'b1, CT_A, 1'b1, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
        check_output("bp_out_valid", 128'(bus.out_valid), 128'd1);
        hs_base = hs_cnt;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_output("bp_hold_valid", 128'(bus.out_valid), 128'd1);
            check_output("bp_hold_data", bus.out_data, CT_A);
            check_output("bp_in_ready", 128'(bus.in_ready), 128'd0);
            check_output("bp_blk_cnt", 128'(bus.blk_cnt), 128'd0);
        end
        bus.out_ready = 1'b1;
        repeat (5) tick();
        check_output("bp_one_handshake", 128'(hs_cnt - hs_base), 128'd1);
        check_output("bp_blk_cnt_after", 128'(bus.blk_cnt), 128'd1);
        check_output("bp_busy_after", 128'(bus.busy), 128'd0);

        $display("[TB] Reserved mode");
        start_msg(2'd3, KEY_A, '0);
        check_output("rsv_err", 128'(bus.err), 128'd1);
        check_output("rsv_busy", 128'(bus.busy), 128'd0);
        check_output("rsv_in_ready", 128'(bus.in_ready), 128'd0);
        tick();
        check_output("rsv_err_sticky", 128'(bus.err), 128'd1);

        $display("[TB] Start while waiting on core");
        start_msg(2'd0, KEY_A, '0);
        check_output("ws_err_cleared", 128'(bus.err), 128'd0);
        apply_stimulus(PT_A, 1'b1, CT_A, 1'b1, 1'b1);
        tick();
        bus.cfg_mode = 2'd1;
        bus.cfg_key  = KEY_B;
        bus.cfg_iv   = IV_CBC;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        check_output("ws_err", 128'(bus.err), 128'd1);
        check_output("ws_busy", 128'(bus.busy), 128'd1);
        wait_msg_done();
        check_output("ws_blk_cnt", 128'(bus.blk_cnt), 128'd1);
        check_output("ws_err_kept", 128'(bus.err), 128'd1);

        $display("[TB] Core timeout");
        start_msg(2'd0, KEY_A, '0);
        force dut.core_done = 1'b0;
        hs_base = hs_cnt;
        apply_stimulus(PT_A, 1'b1, '0, 1'b0, 1'b0);
        check_output("to_ld", 128'(dut.core_ld), 128'd1);
        repeat (TIMEOUT - 1) tick();
        check_output("to_err_early", 128'(bus.err), 128'd0);
        check_output("to_busy_early", 128'(bus.busy), 128'd1);
        tick();
        check_output("to_err", 128'(bus.err), 128'd1);
        check_output("to_busy", 128'(bus.busy), 128'd0);
        release dut.core_done;
        repeat (20) tick();
        check_output("to_no_output", 128'(bus.out_valid), 128'd0);
        check_output("to_no_handshake", 128'(hs_cnt - hs_base), 128'd0);

        $display("[TB] Reset during core wait");
        start_msg(2'd0, KEY_A, '0);
        hs_base = hs_cnt;
        apply_stimulus(PT_A, 1'b1, '0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("mid");
        rst = 1'b0;
        repeat (20) tick();
        check_output("mid_no_output", 128'(bus.out_valid), 128'd0);
        check_output("mid_no_handshake", 128'(hs_cnt - hs_base), 128'd0);

        $display("[TB] ECB after reset");
        start_msg(2'd0, KEY_A, '0);
        apply_stimulus(PT_A, 1'b1, CT_A, 1'b1, 1'b1);
        wait_msg_done();
        check_output("rec_blk_cnt", 128'(bus.blk_cnt), 128'd1);
        check_output("sb_drained", 128'(sb.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_mode_engine.md
Name: aes_mode_engine

Overview:
Streaming block-cipher mode controller that wraps one aes_cipher_top instance. It adds ECB, CBC and CTR modes, valid/ready handshakes on the input and output streams, a chaining and counter register, message framing, a block count, and a core-timeout watchdog. The block sits between the DMA/stream fabric and the raw AES core. It turns the core's single-shot ld/done interface into a backpressured multi-block message engine.

Parameters:
CTR_W, 32, number of low-order counter bits incremented in CTR mode (1..128); upper 128-CTR_W bits never change
CNT_W, 16, width of the blk_cnt output
TIMEOUT, 64, maximum cycles to wait for core done after ld before an error is flagged (>=16)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset; internal core reset driven as ~rst (the core's reset is active-low)
start  in  1  one-cycle pulse; latches cfg_* and begins a message
cfg_mode  in  2  0=ECB, 1=CBC, 2=CTR, 3=reserved
cfg_key  in  128  cipher key, latched on start
cfg_iv  in  128  CBC IV or CTR initial counter, latched on start
in_valid  in  1  input block valid
in_ready  out  1  engine can accept a block
in_data  in  128  plaintext block
in_last  in  1  final block of the message
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_data  out  128  ciphertext block
out_last  out  1  marks the final result of the message
busy  out  1  a message is in progress
err  out  1  sticky error flag
blk_cnt  out  CNT_W  count of results handed off since start; wraps modulo 2^CNT_W

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, err=0, blk_cnt=0. Key, chain and counter registers are cleared to 0. The state goes to IDLE. Reset applied mid-message aborts the message immediately; any in-flight core result is discarded.
- States: IDLE, ARM, LOAD, WAIT, HOLD.
- IDLE:
  - start with mode 0..2: latch key, mode and iv into chain/ctr; clear err and blk_cnt; busy=1; go to ARM.
  - start with mode 3: set err=1 and stay in IDLE.
- start outside IDLE: ignored, and err is set to 1. The current message continues unaffected.
- ARM: in_ready=1 only in this state. A transfer occurs when in_valid && in_ready; the engine captures in_data and in_last and goes to LOAD.
- LOAD: one cycle. The core is driven with ld=1 for exactly this cycle, with key = latched key and text_in as follows:
  - ECB: text_in = P.
  - CBC: text_in = P ^ chain.
  - CTR: text_in = ctr.
  Next state is WAIT.
- WAIT: counts cycles while waiting for core done.
  - On done: out_data = C, where C = core text_out (ECB/CBC) or core text_out ^ P (CTR). out_last = captured in_last; out_valid=1 in the next cycle; go to HOLD.
  - In the same done cycle: CBC sets chain <= C. CTR sets ctr[CTR_W-1:0] <= ctr[CTR_W-1:0] + 1 modulo 2^CTR_W, with the upper bits unchanged.
  - Timeout: if done has not arrived TIMEOUT cycles after ld, set err=1, busy=0, go to IDLE. A late done is ignored.
- HOLD: out_valid and out_data stay stable until out_ready. On the handshake cycle: out_valid drops next cycle and blk_cnt increments. Then:
  - out_last=1: busy=0, go to IDLE.
  - otherwise: go to ARM.
  out_ready while out_valid=0 has no effect.
- One block in flight at a time; no overlap. in_ready stays low from acceptance until the result handshake completes. This gives full backpressure with no output overflow possible.
- Latency: input accepted at cycle N → ld at N+1 → out_valid at D+1, where D is the core done cycle.
- Chain and ctr values persist only within a message; the next start reloads them from cfg_iv.

Test Plan:
- ECB, key 000102030405060708090a0b0c0d0e0f, in_data 00112233445566778899aabbccddeeff, in_last=1 → out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_last=1, blk_cnt=1, busy=0 after the handshake.
- CBC, key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102030405060708090a0b0c0d0e0f. Blocks 6bc1bee22e409f96e93d7e117393172a and ae2d8a571e03ac9c9eb76fac45af8e51 (last) → 7649abac8119b246cee98e9b12e9197d, then 5086cb9b507219ee95db113a917678b2.
- CTR, same key, iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, the same two blocks → 874d6191b620e3261bef6864990db6ce, then 9806f66b7970fdff8617187bb9fffdff.
- CTR wrap, CTR_W=32, iv 00..00_ffffffff: after one block the second core input must be 00..00_00000000, with the upper 96 bits unchanged. Check the core text_in probe.
- Backpressure: hold out_ready=0 for 20 cycles in HOLD → out_data stable, in_ready=0, blk_cnt unchanged. Then release out_ready → exactly one handshake and blk_cnt+1.
- Errors: start with mode 3 → err=1, busy=0. start during WAIT → err=1 and the message completes correctly. Core done forced low → err=1 at ld+TIMEOUT, busy=0. rst mid-WAIT → all outputs at their reset values the next cycle.
